// File: rtl/vga_timing_gen.sv
// Raster timing generator: HSYNC/VSYNC/DE, active-area pixel coordinates and
// frame/line markers, with start/stop control that only stops on frame boundaries.
module vga_timing_gen #(
    parameter int   ADDR_WIDTH = 11,
    parameter int   HACTIVE    = 640,
    parameter int   HFP        = 16,
    parameter int   HSW        = 96,
    parameter int   HBP        = 48,
    parameter int   VACTIVE    = 480,
    parameter int   VFP        = 10,
    parameter int   VSW        = 2,
    parameter int   VBP        = 33,
    parameter logic SYNC_POL   = 1'b0
) (
    input  logic                  VCLK,
    input  logic                  RST,
    input  logic                  iEN,
    output logic                  oHSYNC,
    output logic                  oVSYNC,
    output logic                  oDE,
    output logic [ADDR_WIDTH-1:0] oH_ADDR,
    output logic [ADDR_WIDTH-1:0] oV_ADDR,
    output logic                  oFRAME_START,
    output logic                  oLINE_START,
    output logic                  oBUSY
);

    localparam int HTOTAL = HACTIVE + HFP + HSW + HBP;
    localparam int VTOTAL = VACTIVE + VFP + VSW + VBP;

    localparam logic [ADDR_WIDTH-1:0] H_LAST = ADDR_WIDTH'(HTOTAL - 1);
    localparam logic [ADDR_WIDTH-1:0] V_LAST = ADDR_WIDTH'(VTOTAL - 1);
    localparam logic [ADDR_WIDTH-1:0] H_ACT  = ADDR_WIDTH'(HACTIVE);
    localparam logic [ADDR_WIDTH-1:0] V_ACT  = ADDR_WIDTH'(VACTIVE);
    localparam logic [ADDR_WIDTH-1:0] HS_BEG = ADDR_WIDTH'(HACTIVE + HFP);
    localparam logic [ADDR_WIDTH-1:0] HS_END = ADDR_WIDTH'(HACTIVE + HFP + HSW);
    localparam logic [ADDR_WIDTH-1:0] VS_BEG = ADDR_WIDTH'(VACTIVE + VFP);
    localparam logic [ADDR_WIDTH-1:0] VS_END = ADDR_WIDTH'(VACTIVE + VFP + VSW);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        STOPPING
    } state_t;

    state_t                  state, state_nx;
    logic [ADDR_WIDTH-1:0]   hcnt, vcnt, hcnt_nx, vcnt_nx;
    logic                    frame_end;

    logic                    busy_nx, de_nx, hs_nx, vs_nx, fs_nx, ls_nx;
    logic [ADDR_WIDTH-1:0]   haddr_nx, vaddr_nx;

    always_comb begin
        frame_end = (hcnt == H_LAST) && (vcnt == V_LAST);
        state_nx  = state;
        hcnt_nx   = '0;
        vcnt_nx   = '0;
        case (state)
            IDLE: begin
                if (iEN) state_nx = RUN;
            end
            RUN, STOPPING: begin
                // Only the iEN level at the last pixel of a frame decides whether to stop.
                if (frame_end) state_nx = iEN ? RUN : IDLE;
                else           state_nx = iEN ? RUN : STOPPING;
                if (!frame_end) begin
                    if (hcnt == H_LAST) begin
                        hcnt_nx = '0;
                        vcnt_nx = vcnt + 1'b1;
                    end else begin
                        hcnt_nx = hcnt + 1'b1;
                        vcnt_nx = vcnt;
                    end
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // Outputs are decoded from the next counter values so the registered outputs
    // line up with the counters they describe.
    always_comb begin
        busy_nx  = (state_nx != IDLE);
        de_nx    = busy_nx && (hcnt_nx < H_ACT) && (vcnt_nx < V_ACT);
        hs_nx    = (busy_nx && (hcnt_nx >= HS_BEG) && (hcnt_nx < HS_END)) ? SYNC_POL : ~SYNC_POL;
        vs_nx    = (busy_nx && (vcnt_nx >= VS_BEG) && (vcnt_nx < VS_END)) ? SYNC_POL : ~SYNC_POL;
        haddr_nx = de_nx ? hcnt_nx : '0;
        vaddr_nx = (busy_nx && (vcnt_nx < V_ACT)) ? vcnt_nx : '0;
        fs_nx    = busy_nx && (hcnt_nx == '0) && (vcnt_nx == '0);
        ls_nx    = busy_nx && (hcnt_nx == '0) && (vcnt_nx < V_ACT);
    end

    always_ff @(posedge VCLK or posedge RST) begin
        if (RST) begin
            state        <= IDLE;
            hcnt         <= '0;
            vcnt         <= '0;
            oBUSY        <= 1'b0;
            oDE          <= 1'b0;
            oHSYNC       <= ~SYNC_POL;
            oVSYNC       <= ~SYNC_POL;
            oH_ADDR      <= '0;
            oV_ADDR      <= '0;
            oFRAME_START <= 1'b0;
            oLINE_START  <= 1'b0;
        end else begin
            state        <= state_nx;
            hcnt         <= hcnt_nx;
            vcnt         <= vcnt_nx;
            oBUSY        <= busy_nx;
            oDE          <= de_nx;
            oHSYNC       <= hs_nx;
            oVSYNC       <= vs_nx;
            oH_ADDR      <= haddr_nx;
            oV_ADDR      <= vaddr_nx;
            oFRAME_START <= fs_nx;
            oLINE_START  <= ls_nx;
        end
    end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: small raster, frame-position reference model,
// directed start/stop/reset scenarios plus random iEN activity.
module tb_vga_timing_gen;

    localparam int   AW  = 11;
    localparam int   HA  = 10, HFP = 2, HSW = 3, HBP = 2;
    localparam int   VA  = 6,  VFP = 1, VSW = 2, VBP = 2;
    localparam logic SP  = 1'b0;
    localparam int   HT  = HA + HFP + HSW + HBP;
    localparam int   VT  = VA + VFP + VSW + VBP;
    localparam int   FRAME = HT * VT;

    logic          VCLK = 1'b0;
    logic          RST  = 1'b1;
    logic          iEN  = 1'b0;
    logic          oHSYNC, oVSYNC, oDE, oFRAME_START, oLINE_START, oBUSY;
    logic [AW-1:0] oH_ADDR, oV_ADDR;

    int n_checks = 0;
    int n_err    = 0;

    // Reference: running flag plus linear pixel position within the frame.
    bit m_run = 1'b0;
    int m_pos = 0;

    always #5 VCLK = ~VCLK;

    vga_timing_gen #(
        .ADDR_WIDTH(AW), .HACTIVE(HA), .HFP(HFP), .HSW(HSW), .HBP(HBP),
        .VACTIVE(VA), .VFP(VFP), .VSW(VSW), .VBP(VBP), .SYNC_POL(SP)
    ) dut (
        .VCLK(VCLK), .RST(RST), .iEN(iEN),
        .oHSYNC(oHSYNC), .oVSYNC(oVSYNC), .oDE(oDE),
        .oH_ADDR(oH_ADDR), .oV_ADDR(oV_ADDR),
        .oFRAME_START(oFRAME_START), .oLINE_START(oLINE_START), .oBUSY(oBUSY)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_update(input logic en);
        if (RST) m_run = 1'b0;
        else if (!m_run) begin
            if (en) begin m_run = 1'b1; m_pos = 0; end
        end else if (m_pos == FRAME - 1) begin
            if (en) m_pos = 0;
            else    m_run = 1'b0;
        end else m_pos++;
    endtask

    task automatic check_outputs();
        int h, v;
        bit de, hs, vs;
        h  = m_pos % HT;
        v  = m_pos / HT;
        de = m_run && h < HA && v < VA;
        hs = m_run && h >= HA + HFP && h < HA + HFP + HSW;
        vs = m_run && v >= VA + VFP && v < VA + VFP + VSW;
        chk("busy",   oBUSY, m_run);
        chk("de",     oDE, de);
        chk("hsync",  oHSYNC, hs ? SP : !SP);
        chk("vsync",  oVSYNC, vs ? SP : !SP);
        chk("h_addr", oH_ADDR, de ? h : 0);
        chk("v_addr", oV_ADDR, (m_run && v < VA) ? v : 0);
        chk("frame_start", oFRAME_START, m_run && m_pos == 0);
        chk("line_start",  oLINE_START, m_run && h == 0 && v < VA);
    endtask

    task automatic step(input logic en);
        iEN = en;
        @(posedge VCLK);
        model_update(en);
        @(negedge VCLK);
        check_outputs();
    endtask

    initial begin
        int de_cnt, ls_cnt, fs_cnt, guard;

        // Reset held, then released with iEN low for 100 cycles.
        repeat (3) @(negedge VCLK);
        check_outputs();
        RST = 1'b0;
        repeat (100) step(1'b0);

        // Start and count one full frame of markers.
        de_cnt = 0; ls_cnt = 0; fs_cnt = 0;
        step(1'b1);
        chk("first_frame_start", oFRAME_START, 1);
        for (int i = 0; i < FRAME; i++) begin
            de_cnt += int'(oDE);
            ls_cnt += int'(oLINE_START);
            fs_cnt += int'(oFRAME_START);
            if (i != FRAME - 1) step(1'b1);
        end
        chk("de_per_frame", de_cnt, HA * VA);
        chk("ls_per_frame", ls_cnt, VA);
        chk("fs_per_frame", fs_cnt, 1);

        // Drop iEN on line 3 of the next frame: frame completes, then idle.
        while (m_pos / HT != 3) step(1'b1);
        fs_cnt = 0; guard = 0;
        while (m_run && guard < 2 * FRAME) begin
            step(1'b0);
            fs_cnt += int'(oFRAME_START);
            guard++;
        end
        chk("stop_cycles", guard, FRAME - 3 * HT);
        chk("no_second_frame_start", fs_cnt, 0);
        repeat (20) step(1'b0);

        // Drop at line 2, re-raise at line 6: frames continue uninterrupted.
        step(1'b1);
        while (m_pos / HT != 2) step(1'b1);
        while (m_pos / HT != 6) step(1'b0);
        repeat (2 * FRAME) step(1'b1);

        // Random iEN activity.
        for (int seg = 0; seg < 60; seg++) begin
            logic en;
            int len;
            en  = 1'($urandom_range(0, 1));
            len = int'($urandom_range(1, 80));
            repeat (len) step(en);
        end

        // Asynchronous reset mid-line on line 2.
        step(1'b1);
        guard = 0;
        while (!(m_run && m_pos / HT == 2 && m_pos % HT == HA / 2) && guard < 3 * FRAME) begin
            step(1'b1);
            guard++;
        end
        chk("reach_mid_line", guard < 3 * FRAME, 1);
        RST = 1'b1;
        #1;
        m_run = 1'b0;
        check_outputs();
        step(1'b1);
        step(1'b1);
        RST = 1'b0;
        step(1'b1);
        chk("restart_frame_start", oFRAME_START, 1);
        repeat (FRAME + 5) step(1'b1);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
